// File: rtl/lfsr_decrypter_if.sv
// Byte-stream handshake bundle for lfsr_decrypter.
//   InValid/InData/InReady    : encrypted byte stream into the block
//   OutValid/OutData/OutReady : decrypted byte stream out of the block
// slave is the decrypter side, master is the producer/consumer side.
interface lfsr_decrypter_if #(parameter int W = 8);
  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;
  logic         OutValid;
  logic [W-1:0] OutData;
  logic         OutReady;

  modport master (output InValid, InData, OutReady,
                  input  InReady, OutValid, OutData);
  modport slave  (input  InValid, InData, OutReady,
                  output InReady, OutValid, OutData);
endinterface

// File: rtl/lfsr_decrypter.sv
// Stream decrypter: XORs each payload with a 7-bit Fibonacci LFSR keystream
// and checks even parity of the cipher payload.
//   Clk, Reset      : single clock, synchronous active-high reset
//   Start           : begin a message (only honoured in IDLE)
//   Taps/Seed/Len   : LFSR taps, LFSR start state, byte count; sampled on Start
//   bus (slave)     : input and output valid/ready byte streams
//   Busy            : message in progress (RUN or DRAIN)
//   Done            : one-cycle pulse when a message completes
//   ParityErr       : sticky parity-mismatch flag for the current message
//   ErrCount        : parity mismatch count, saturating at 63
module lfsr_decrypter #(
  parameter int W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [6:0]        Taps,
  input  logic [6:0]        Seed,
  input  logic [5:0]        Len,
  lfsr_decrypter_if.slave   bus,
  output logic              Busy,
  output logic              Done,
  output logic              ParityErr,
  output logic [5:0]        ErrCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t       r_state, w_state_nxt;
  logic [6:0]   r_lfsr, r_taps;
  logic [5:0]   r_remain;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_done, r_perr;
  logic [5:0]   r_errcnt;

  logic         w_in_ready, w_in_xfer, w_out_xfer, w_start_acc;
  logic         w_par_bad;
  logic [W-2:0] w_ks;

  // Output register is free when empty or being drained this cycle, which
  // gives one byte per cycle under a continuously ready consumer.
  assign w_in_ready  = (r_state == S_RUN) && (!r_out_valid || bus.OutReady);
  assign w_in_xfer   = bus.InValid && w_in_ready;
  assign w_out_xfer  = r_out_valid && bus.OutReady;
  assign w_start_acc = (r_state == S_IDLE) && Start;
  assign w_par_bad   = bus.InData[W-1] != (^bus.InData[W-2:0]);

  always_comb begin
    w_ks      = '0;
    w_ks[6:0] = r_lfsr;
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start && Len != 6'd0)            w_state_nxt = S_RUN;
      S_RUN:   if (w_in_xfer && r_remain == 6'd1)   w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_xfer)                      w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr      <= '0;
      r_taps      <= '0;
      r_remain    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_perr      <= 1'b0;
      r_errcnt    <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_start_acc) begin
        r_lfsr   <= Seed;
        r_taps   <= Taps;
        r_remain <= Len;
        r_perr   <= 1'b0;
        r_errcnt <= '0;
        // Empty message completes immediately without leaving IDLE.
        r_done   <= (Len == 6'd0);
      end

      if (w_in_xfer) begin
        r_out_data <= {1'b0, bus.InData[W-2:0] ^ w_ks};
        r_lfsr     <= {r_lfsr[5:0], ^(r_lfsr & r_taps)};
        r_remain   <= r_remain - 6'd1;
        // A bad byte is still decrypted and forwarded; only the flags record it.
        if (w_par_bad) begin
          r_perr <= 1'b1;
          if (r_errcnt != 6'd63) r_errcnt <= r_errcnt + 6'd1;
        end
      end

      if (w_in_xfer)       r_out_valid <= 1'b1;
      else if (w_out_xfer) r_out_valid <= 1'b0;

      if (r_state == S_DRAIN && w_out_xfer) r_done <= 1'b1;
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = r_out_valid;
  assign bus.OutData  = r_out_data;
  assign Busy         = (r_state != S_IDLE);
  assign Done         = r_done;
  assign ParityErr    = r_perr;
  assign ErrCount     = r_errcnt;

endmodule

// File: tb/tb_lfsr_decrypter.sv
module tb_lfsr_decrypter;
  localparam int W = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [6:0] Taps = '0;
  logic [6:0] Seed = '0;
  logic [5:0] Len = '0;
  logic       Busy, Done, ParityErr;
  logic [5:0] ErrCount;

  int n_chk = 0;
  int n_err = 0;

  lfsr_decrypter_if #(.W(W)) bus ();

  lfsr_decrypter #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Taps(Taps), .Seed(Seed), .Len(Len),
    .bus(bus.slave), .Busy(Busy), .Done(Done), .ParityErr(ParityErr), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // n-th keystream word from the seed: shift left, feedback = parity of tapped bits
  function automatic logic [6:0] ks(input logic [6:0] s, input logic [6:0] t, input int n);
    logic [6:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[5:0], ^(v & t)};
    return v;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit         m_on = 0;
  bit         m_active, m_ov, m_done, m_perr;
  int         m_left, m_idx, m_cnt;
  logic [6:0] m_seed, m_taps;
  logic [7:0] m_od;

  always @(negedge Clk) begin : model
    bit ir, ix, ox, act0;
    ir = m_active && m_left > 0 && (!m_ov || bus.OutReady);
    if (m_on) begin
      chk("OutValid", bus.OutValid, m_ov);
      chk("OutData", bus.OutData, m_od);
      chk("InReady", bus.InReady, ir);
      chk("Busy", Busy, m_active);
      chk("Done", Done, m_done);
      chk("ParityErr", ParityErr, m_perr);
      chk("ErrCount", ErrCount, m_cnt);
    end
    if (Reset) begin
      m_on = 1; m_active = 0; m_ov = 0; m_done = 0; m_perr = 0;
      m_left = 0; m_idx = 0; m_cnt = 0; m_seed = 0; m_taps = 0; m_od = 0;
    end else if (m_on) begin
      act0 = m_active;
      ix = ir && bus.InValid;
      ox = m_ov && bus.OutReady;
      m_done = 0;
      if (act0 && m_left == 0 && ox) begin
        m_active = 0;
        m_done = 1;
      end
      if (ix) begin
        m_od = {1'b0, bus.InData[6:0] ^ ks(m_seed, m_taps, m_idx)};
        if (bus.InData[7] != ^bus.InData[6:0]) begin
          m_perr = 1;
          if (m_cnt < 63) m_cnt++;
        end
        m_idx++;
        m_left--;
      end
      m_ov = ix ? 1'b1 : (ox ? 1'b0 : m_ov);
      if (!act0 && Start) begin
        m_seed = Seed; m_taps = Taps; m_left = Len; m_idx = 0;
        m_perr = 0; m_cnt = 0;
        if (Len == 0) m_done = 1;
        else          m_active = 1;
      end
    end
  end

  // ---------------- observation for directed literal checks ----------------
  logic [7:0] got[$];
  int n_in = 0;
  int n_done = 0;

  always @(negedge Clk) begin
    if (bus.OutValid && bus.OutReady) got.push_back(bus.OutData);
    if (bus.InValid && bus.InReady) n_in++;
    if (Done) n_done++;
  end

  function automatic logic [31:0] gb(input int i);
    return (got.size() > i) ? {24'd0, got[i]} : 32'hxxxx_xxxx;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic start(input logic [6:0] t, input logic [6:0] s, input logic [5:0] l);
    Taps = t; Seed = s; Len = l; Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    ok = 0;
    bus.InValid = 1'b1;
    bus.InData  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      ok = bus.InReady;
      @(posedge Clk); #1;
    end
    bus.InValid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      ok = Done;
      @(posedge Clk); #1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    bus.InValid = 1'b0; bus.InData = '0; bus.OutReady = 1'b1;
    cyc(2);
    chk("rst_busy", Busy, 0);
    chk("rst_outvalid", bus.OutValid, 0);
    chk("rst_errcount", ErrCount, 0);
    Reset = 1'b0;
    cyc();

    // keystream 01,02 over payload 40 with correct parity
    got.delete();
    start(7'h60, 7'h01, 6'd2);
    push(8'hC0); push(8'hC0);
    wait_done(20);
    chk("t1_n", got.size(), 2);
    chk("t1_b0", gb(0), 8'h41);
    chk("t1_b1", gb(1), 8'h42);
    chk("t1_perr", ParityErr, 0);

    // parity error still decrypts; flags hold after Done
    got.delete();
    start(7'h60, 7'h01, 6'd1);
    push(8'h40);
    wait_done(20);
    chk("t2_b0", gb(0), 8'h41);
    chk("t2_perr", ParityErr, 1);
    chk("t2_cnt", ErrCount, 1);
    cyc(3);
    chk("t2_hold", {ParityErr, ErrCount}, {1'b1, 6'd1});

    // backpressure: only one byte consumed while consumer stalls
    got.delete(); n_in = 0;
    start(7'h60, 7'h01, 6'd3);
    bus.OutReady = 1'b0; bus.InValid = 1'b1; bus.InData = 8'hC0;
    cyc(6);
    chk("t3_stall_in", n_in, 1);
    chk("t3_stall_rdy", bus.InReady, 0);
    chk("t3_stall_data", bus.OutData, 8'h41);
    bus.OutReady = 1'b1;
    wait_done(20);
    bus.InValid = 1'b0;
    chk("t3_in", n_in, 3);
    chk("t3_b0", gb(0), 8'h41);
    chk("t3_b1", gb(1), 8'h42);
    chk("t3_b2", gb(2), 8'h44);

    // zero length: single Done, nothing consumed
    n_done = 0; n_in = 0; bus.InValid = 1'b1; bus.InData = 8'hC0;
    start(7'h60, 7'h01, 6'd0);
    cyc(5);
    bus.InValid = 1'b0;
    chk("t4_done", n_done, 1);
    chk("t4_in", n_in, 0);

    // reset mid-message, then a clean restart
    start(7'h60, 7'h01, 6'd3);
    push(8'h40);
    n_done = 0;
    Reset = 1'b1; cyc(); Reset = 1'b0;
    chk("t5_outs", {bus.OutValid, Busy, Done, ParityErr, ErrCount, bus.InReady}, 0);
    chk("t5_data", bus.OutData, 0);
    cyc(2);
    chk("t5_nodone", n_done, 0);
    got.delete();
    start(7'h60, 7'h01, 6'd2);
    push(8'hC0); push(8'hC0);
    wait_done(20);
    chk("t5_b0", gb(0), 8'h41);
    chk("t5_b1", gb(1), 8'h42);

    // Start during RUN is ignored
    got.delete();
    start(7'h60, 7'h01, 6'd2);
    push(8'hC0);
    start(7'h7F, 7'h55, 6'd5);
    push(8'hC0);
    wait_done(20);
    chk("t6_n", got.size(), 2);
    chk("t6_b0", gb(0), 8'h41);
    chk("t6_b1", gb(1), 8'h42);

    // Seed=0 passes data through; Taps=0 shifts zeros in
    got.delete();
    start(7'h00, 7'h00, 6'd2);
    push(8'h03); push(8'hC5);
    wait_done(20);
    chk("t7_b0", gb(0), 8'h03);
    chk("t7_b1", gb(1), 8'h45);
    got.delete();
    start(7'h00, 7'h40, 6'd3);
    push(8'hC0); push(8'hC0); push(8'hC0);
    wait_done(20);
    chk("t7_b2", gb(0), 8'h00);
    chk("t7_b3", gb(1), 8'h40);
    chk("t7_b4", gb(2), 8'h40);
    chk("t7_perr", ParityErr, 0);

    // 63 bad bytes reach the counter ceiling
    start(7'h60, 7'h01, 6'd63);
    bus.InValid = 1'b1; bus.InData = 8'h40;
    wait_done(200);
    bus.InValid = 1'b0;
    chk("t8_cnt", ErrCount, 63);
    chk("t8_perr", ParityErr, 1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
